// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream receive and instruction-memory write port bundle
interface imem_loader_if;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  modport master (
    input  i_rx_valid, i_rx_data,
    output o_rx_ready, o_wr_en, o_wr_addr, o_wr_data
  );
  modport slave (
    output i_rx_valid, i_rx_data,
    input  o_rx_ready, o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: parses a length/words/checksum byte frame into instruction memory writes
module imem_loader #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic         i_clk,
  input  logic         i_reset,
  imem_loader_if.master bus,
  output logic         o_cpu_reset,
  output logic         o_done,
  output logic         o_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d, n_len;
  logic [AW-1:0]   widx_q, widx_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [7:0]      sum_q, sum_d;
  logic [31:0]     word_q, word_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic            take;
  assign take            = bus.i_rx_valid && bus.o_rx_ready;
  assign n_len           = {bus.i_rx_data, len_q[7:0]};
  assign bus.o_rx_ready  = (state_q != S_DONE) && (state_q != S_ERR);
  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign o_cpu_reset     = state_q != S_DONE;
  assign o_done          = state_q == S_DONE;
  assign o_error         = state_q == S_ERR;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    sum_d     = sum_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (take) begin
      case (state_q)
        S_LEN0: begin
          len_d   = {8'h00, bus.i_rx_data};
          state_d = S_LEN1;
        end
        S_LEN1: begin
          len_d   = n_len;
          widx_d  = '0;
          bidx_d  = '0;
          sum_d   = '0;
          state_d = (n_len == 16'd0 || 32'(n_len) > 32'(DEPTH_WORDS)) ? S_ERR : S_DATA;
        end
        S_DATA: begin
          word_d[{bidx_q, 3'b000} +: 8] = bus.i_rx_data;
          sum_d  = sum_q + bus.i_rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 32'({widx_q, 2'b00});
            wr_data_d = word_d;
            widx_d    = widx_q + AW'(1);
            state_d   = (16'(widx_q) == len_q - 16'd1) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: state_d = (bus.i_rx_data == sum_q) ? S_DONE : S_ERR;
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_LEN0;
      len_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      sum_q     <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      sum_q     <= sum_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame scoreboard bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  logic cpu_reset, done, error;
  imem_loader_if bus();
  imem_loader #(.DEPTH_WORDS(2048)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus),
    .o_cpu_reset(cpu_reset),
    .o_done(done),
    .o_error(error)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] preset[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        prev_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.o_wr_en) begin
      chk("strobe_width", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.o_wr_addr, bus.o_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.o_wr_addr, e.addr);
        chk("wr_data", bus.o_wr_data, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_en = !rst && bus.o_wr_en;
  end
  task automatic chk_reset_vals();
    chk("rst_rx_ready", 32'(bus.o_rx_ready), 32'd1);
    chk("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    chk("rst_wr_addr", bus.o_wr_addr, 32'd0);
    chk("rst_wr_data", bus.o_wr_data, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_rx_valid = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask
  task automatic send(input logic [7:0] b, input int gmax, output int acc);
    int t;
    t = 0;
    repeat ($urandom_range(gmax, 0)) begin
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
    end
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    while (!bus.o_rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    acc = cyc;
    @(posedge clk);
  endtask
  task automatic frame(input int n, input int adj, input int gmax);
    logic [15:0] len;
    logic [7:0]  sum;
    logic [31:0] w;
    int          acc;
    bit          ok;
    len = 16'(n);
    sum = 8'h00;
    ok  = (adj % 256) == 0;
    send(len[7:0], gmax, acc);
    send(len[15:8], gmax, acc);
    if (n < 1 || n > 2048) begin
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      chk("badlen_error", 32'(error), 32'd1);
      chk("badlen_done", 32'(done), 32'd0);
      chk("badlen_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("badlen_rx_ready", 32'(bus.o_rx_ready), 32'd0);
      repeat (6) @(negedge clk);
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = (preset.size() > 0) ? preset.pop_front() : $urandom;
      for (int b = 0; b < 4; b++) begin
        send(w[8*b +: 8], gmax, acc);
        sum = sum + w[8*b +: 8];
        if (b == 3) exp_q.push_back('{32'(4 * k), w, acc + 1});
      end
    end
    send(sum + 8'(adj), gmax, acc);
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    chk("end_done", 32'(done), 32'(ok));
    chk("end_error", 32'(error), 32'(!ok));
    chk("end_cpu_reset", 32'(cpu_reset), 32'(!ok));
    chk("end_rx_ready", 32'(bus.o_rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("writes_missing", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic mid_reset();
    logic [31:0] w;
    int          acc;
    send(8'h02, 0, acc);
    send(8'h00, 0, acc);
    w = $urandom;
    for (int b = 0; b < 4; b++) begin
      send(w[8*b +: 8], 1, acc);
      if (b == 3) exp_q.push_back('{32'd0, w, acc + 1});
    end
    w = $urandom;
    send(w[7:0], 1, acc);
    send(w[15:8], 1, acc);
    @(negedge clk);
    rst = 1'b1;
    bus.i_rx_valid = 1'b0;
    #1;
    chk("mid_word0_written", 32'(exp_q.size()), 32'd0);
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame(1, 0, 1);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    do_reset();
    preset.push_back(32'h0000_0013);
    frame(1, 0, 0);
    do_reset();
    preset.push_back(32'h0050_0093);
    preset.push_back(32'h00A0_0113);
    preset.push_back(32'h0020_81B3);
    frame(3, 0, 3);
    do_reset();
    frame(0, 0, 1);
    do_reset();
    frame(2049, 0, 1);
    do_reset();
    frame(2, 1, 2);
    do_reset();
    frame(2048, 0, 0);
    do_reset();
    mid_reset();
    repeat (8) begin
      do_reset();
      frame($urandom_range(1, 6), $urandom_range(0, 1) ? 0 : $urandom_range(1, 255), $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream boot loader that writes a program image into the instruction memory's 8 KB word array (2048 words) before the core runs. It parses a framed byte stream of length, little-endian instruction words and checksum, and issues one word write per instruction. It holds the core in reset until a complete, checksum-verified image is loaded. It sits between a UART/debug byte source and the instruction memory write port.

## Interface
- `DEPTH_WORDS`, default 2048: instruction memory capacity in words; legal word counts are 1..DEPTH_WORDS.
- `i_clk`  in  1  system clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rx_valid`  in  1  input byte valid.
- `i_rx_data`  in  8  input byte.
- `o_rx_ready`  out  1  loader accepts a byte; a transfer occurs when `i_rx_valid && o_rx_ready` at a rising edge.
- `o_wr_en`  out  1  one-cycle instruction memory write strobe.
- `o_wr_addr`  out  32  byte address of the word being written; always word-aligned, bits [1:0] = 0.
- `o_wr_data`  out  32  word to write.
- `o_cpu_reset`  out  1  core reset request; high until the load succeeds.
- `o_done`  out  1  image loaded and verified; sticky.
- `o_error`  out  1  framing or checksum failure; sticky.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes, then one CSUM byte.
  - Data bytes are grouped least-significant byte first per word.
  - CSUM is the 8-bit modulo-256 sum of all 4·N data bytes. The length bytes are excluded from the sum.
- States and transitions:
  - S_LEN0: capture LEN_LO, go to S_LEN1.
  - S_LEN1: capture LEN_HI.
    - If N == 0 or N > DEPTH_WORDS, go to S_ERR.
    - Otherwise clear the word index, byte index and sum, and go to S_DATA.
  - S_DATA: shift each byte into the word register at lane = byte index, and add it to the sum.
    - On the 4th byte, schedule the write and increment the word index.
    - After word N−1 completes, go to S_CSUM.
  - S_CSUM: if the received byte equals the sum, go to S_DONE; otherwise go to S_ERR.
  - S_DONE and S_ERR are terminal until `i_reset`.
- `o_rx_ready` is a combinational decode of state: 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM; 0 in S_DONE and S_ERR.
- Write port behaviour:
  - `o_wr_en`, `o_wr_addr` and `o_wr_data` are registered.
  - `o_wr_addr` = word_index·4, so word k lands at byte address 4k.
  - `o_wr_data` is the assembled word.
  - No other writes are issued.
- Writes already issued before an error are not rolled back. `o_cpu_reset` stays high after an error, so the partial image is never executed.
- Sum arithmetic is 8-bit, wrapping. Word index is 11 bits plus the terminal compare against N; the address never exceeds 0x1FFC.
- Outputs by state:
  - `o_cpu_reset` = 1 in every state except S_DONE.
  - `o_done` = 1 only in S_DONE.
  - `o_error` = 1 only in S_ERR.
- Reset values: state S_LEN0, `o_rx_ready` 1, `o_wr_en` 0, `o_wr_addr` 0, `o_wr_data` 0, `o_cpu_reset` 1, `o_done` 0, `o_error` 0, internal sum, counters and length all 0.
- Reset mid-operation: all state is abandoned immediately (asynchronous reset). The next byte after reset release is treated as LEN_LO. A pending write strobe is cleared and not issued.

## Timing
- Throughput: one byte per cycle sustained; `o_rx_ready` never drops inside S_LEN0..S_CSUM.
- Write latency: `o_wr_en` is high for exactly one cycle, the cycle after the edge that accepts a word's 4th byte.
  - Back-to-back words therefore produce strobes at least 4 cycles apart.
- The last word's write strobe may coincide with acceptance of CSUM; both are handled.
- After the CSUM byte is accepted at edge t, at edge t+1:
  - success: `o_done` = 1, `o_cpu_reset` = 0, `o_rx_ready` = 0;
  - failure: `o_error` = 1.
- Bad-length error: `o_error` = 1 the cycle after LEN_HI is accepted, with no writes issued.
- Gaps (`i_rx_valid` low) at any point only stall the parser; no timeout.

## Test plan
- **Single word:** stream 01 00 13 00 00 00 13 → one write, addr 0x0, data 0x00000013; then `o_done` = 1, `o_cpu_reset` = 0, `o_rx_ready` = 0.
- **Three words with random valid gaps:** words 0x00500093, 0x00A00113, 0x002081B3.
  - Required: writes at addresses 0x0, 0x4, 0x8 with matching data.
  - Each strobe is exactly one cycle.
  - `o_done` is set after a correct CSUM.
- **Bad length:**
  - N = 0 → `o_error` = 1 the cycle after LEN_HI, zero writes.
  - N = 2049 (01 08) → same response.
- **Checksum mismatch:** 2-word frame with CSUM off by 1 → both writes occur, `o_error` = 1, `o_done` = 0, `o_cpu_reset` stays 1, `o_rx_ready` = 0.
- **Full depth:** N = 2048 (00 08) → 2048 writes, last at 0x1FFC, `o_done` = 1.
- **Reset mid-load:** assert `i_reset` after the 2nd data byte of word 1 → no write for that word, all outputs return to reset values. A fresh 1-word frame then loads correctly at address 0x0.
